sub_bytes_iter: RTL and testbench

Iterative, parametrised AES SubBytes engine. Replaces the purely combinational SubBytes with a handshaked unit that substitutes the 128-bit state using `LANES` byte S-box instances over `16/LANES` cycles, trading area for latency. It adds an optional inverse-S-box mode so that one block serves both the cipher round and the inverse-cipher round datapaths.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_sbox.sv | 18 +
 rtl/sub_bytes_iter.sv | 115 +++++++++++
 tb/tb_sub_bytes_iter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES byte-substitution tables, engine FSM states and byte-access helper
// shared by the iterative SubBytes engine.
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte 0 is the leftmost (lowest-numbered) byte of an ascending [0:127] vector.
  function automatic logic [7:0] get_byte(input logic [0:127] v, input int unsigned i);
    return v[i*8 +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup; the inverse table exists only when INV_EN is set.
module aes_sbox
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [7:0] byte_i,
  input  logic       inv_i,
  output logic [7:0] byte_o
);

  if (INV_EN) begin : g_inv
    always_comb byte_o = inv_i ? INV_SBOX[byte_i] : SBOX[byte_i];
  end else begin : g_fwd
    always_comb byte_o = SBOX[byte_i];
  end

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative handshaked AES SubBytes: LANES bytes per cycle over 16/LANES cycles,
// with optional inverse substitution selected per block.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter bit          INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [0:127] msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] msgout,
  output logic         busy
);

  localparam int unsigned N  = 16 / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [0:127]    st_q, st_d;
  logic [0:127]    res_q, res_d;
  logic            mode_q, mode_d;
  logic            accept;
  logic [31:0]     base_idx;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  always_comb begin
    base_idx = 32'(cnt_q) * LANES;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = get_byte(st_q, base_idx + l);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox #(.INV_EN(INV_EN)) u_sbox (
      .byte_i (lane_in[g]),
      .inv_i  (mode_q),
      .byte_o (lane_out[g])
    );
  end

  // The result register is separate from the working state so msgout keeps the
  // last completed block while the next one is being substituted.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    res_d    = res_q;
    mode_d   = mode_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      S_RUN: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          st_d[(base_idx + l)*8 +: 8] = lane_out[l];
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          res_d   = st_d;
        end
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          state_d = S_IDLE;
          accept  = in_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      st_d    = msg;
      mode_d  = inv & INV_EN;
      cnt_d   = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign msgout    = res_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: six configurations share one stimulus stream and are
// checked every cycle against a transaction-level model built on arithmetic S-boxes.
module tb_sub_bytes_iter;

  localparam int NI = 6;
  localparam int unsigned LN  [NI] = '{4, 1, 2, 8, 16, 4};
  localparam bit          IE  [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam int          LAT [NI] = '{4, 16, 8, 2, 1, 4};

  localparam logic [0:127] P0 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [0:127] C0 = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [0:127] P1 = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [0:127] C1 = 128'ha761ca9b97be8b45d8ad1a611fc97369;
  localparam logic [0:127] F0 = 128'hfb74a9f201ed70d1bdd0e194f451f864;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         inv = 1'b0;
  logic         out_ready = 1'b1;
  logic [0:127] msg = '0;

  logic         in_ready_w  [NI];
  logic         out_valid_w [NI];
  logic         busy_w      [NI];
  logic [0:127] msgout_w    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_bytes_iter #(.LANES(LN[g]), .INV_EN(IE[g])) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .inv       (inv),
      .msg       (msg),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .msgout    (msgout_w[g]),
      .busy      (busy_w[g])
    );
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  // Model: 0 = idle, 1 = substituting, 2 = result waiting for the consumer.
  int           m_st  [NI];
  int           m_cnt [NI];
  logic [0:127] m_cur [NI];
  logic [0:127] m_res [NI];

  bit           seen [NI];
  int           lat  [NI];
  int           ovc  [NI];
  logic [0:127] got  [NI];
  int           since;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      fwd_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
  endtask

  function automatic logic [0:127] subst(input logic [0:127] m, input bit iv);
    logic [0:127] r;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = m[i*8 +: 8];
      r[i*8 +: 8] = iv ? inv_t[b] : fwd_t[b];
    end
    return r;
  endfunction

  function automatic bit model_ready(input int k);
    return (m_st[k] == 0) || (m_st[k] == 2 && out_ready);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    bit rdy [NI];
    bit acc;
    for (int k = 0; k < NI; k++) rdy[k] = model_ready(k);
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_st[k]  = 0;
        m_cnt[k] = 0;
        m_res[k] = '0;
      end else begin
        acc = in_valid && rdy[k];
        case (m_st[k])
          1: begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
              m_st[k]  = 2;
              m_res[k] = m_cur[k];
            end
          end
          2: if (out_ready) m_st[k] = 0;
          default: ;
        endcase
        if (acc) begin
          m_cur[k] = subst(msg, inv && IE[k]);
          m_cnt[k] = 16 / int'(LN[k]);
          m_st[k]  = 1;
        end
      end
    end
    #1;
    since++;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("in_ready[%0d]", k), in_ready_w[k], model_ready(k));
      check($sformatf("out_valid[%0d]", k), out_valid_w[k], m_st[k] == 2);
      check($sformatf("busy[%0d]", k), busy_w[k], m_st[k] != 0);
      check($sformatf("msgout[%0d]", k), msgout_w[k], m_res[k]);
      if (out_valid_w[k] === 1'b1) begin
        ovc[k]++;
        if (!seen[k]) begin
          seen[k] = 1'b1;
          lat[k]  = since;
          got[k]  = msgout_w[k];
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [0:127] m, input bit iv);
    msg      = m;
    inv      = iv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    since    = 0;
    for (int k = 0; k < NI; k++) begin
      seen[k] = 1'b0;
      ovc[k]  = 0;
    end
  endtask

  task automatic expect_res(input string tag, input int k, input logic [0:127] exp);
    check($sformatf("%s_timeout[%0d]", tag, k), seen[k], 1'b1);
    check($sformatf("%s_latency[%0d]", tag, k), lat[k], LAT[k]);
    check($sformatf("%s_result[%0d]", tag, k), got[k], exp);
  endtask

  initial begin
    build_tables();
    check("sbox_00", fwd_t[8'h00], 8'h63);
    check("sbox_53", fwd_t[8'h53], 8'hed);
    check("sbox_ff", fwd_t[8'hff], 8'h16);
    check("isbox_63", inv_t[8'h63], 8'h00);
    check("isbox_16", inv_t[8'h16], 8'hff);

    rst = 1'b1;
    run(2);
    rst = 1'b0;
    check("reset_msgout", msgout_w[0], 128'h0);
    check("reset_in_ready", in_ready_w[0], 1'b1);

    send(P0, 1'b0);
    run(18);
    for (int k = 0; k < NI; k++) expect_res("fwd0", k, C0);

    send(P1, 1'b0);
    run(18);
    for (int k = 0; k < NI; k++) expect_res("fwd1", k, C1);

    send(C0, 1'b1);
    run(18);
    for (int k = 0; k < NI; k++) expect_res("inv", k, (IE[k] ? P0 : F0));

    out_ready = 1'b0;
    send(P1, 1'b0);
    run(16);
    run(5);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("bp_out_valid[%0d]", k), out_valid_w[k], 1'b1);
      check($sformatf("bp_in_ready[%0d]", k), in_ready_w[k], 1'b0);
      check($sformatf("bp_msgout[%0d]", k), msgout_w[k], C1);
    end
    out_ready = 1'b1;
    send(P0, 1'b0);
    run(18);
    for (int k = 0; k < NI; k++) expect_res("b2b", k, C0);

    send(P1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid_w[1], 1'b0);
    check("rst_msgout", msgout_w[1], 128'h0);
    check("rst_in_ready", in_ready_w[1], 1'b1);
    check("rst_busy", busy_w[1], 1'b0);
    run(18);
    check("rst_no_output", ovc[1], 0);
    send(C1, 1'b1);
    run(18);
    expect_res("post_rst", 1, P1);

    send(P1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2 == 0);
      msg      = P0;
      inv      = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    run(18);
    expect_res("ign", 0, C1);
    expect_res("ign", 1, C1);
    expect_res("ign", 2, C1);
    expect_res("ign", 5, C1);
    check("ign_count[1]", ovc[1], 1);
    check("ign_count[0]", ovc[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
